// File: rtl/vend_sequencer_if.sv
// Selection, restock and dispense signals of the vending sequencer, grouped for port use.
// The bench drives the master side; the sequencer implements the slave side.
interface vend_sequencer_if;
   logic        sel_valid;
   logic [3:0]  sel_index;
   logic        sel_ready;
   logic [7:0]  credit;
   logic        restock_valid;
   logic [3:0]  restock_index;
   logic [2:0]  restock_count;
   logic        reduceInventory;
   logic        reduceInventoryDone;
   logic [3:0]  curIndex;
   logic [23:0] curInventory;
   logic [1:0]  state;
   logic        vend_ok;
   logic        vend_fail;
   logic [1:0]  fail_code;
   logic [7:0]  change;
   logic        fault;

   modport master (
      output sel_valid, sel_index, credit, restock_valid, restock_index, restock_count,
             reduceInventoryDone,
      input  sel_ready, reduceInventory, curIndex, curInventory, state, vend_ok, vend_fail,
             fail_code, change, fault
   );

   modport slave (
      input  sel_valid, sel_index, credit, restock_valid, restock_index, restock_count,
             reduceInventoryDone,
      output sel_ready, reduceInventory, curIndex, curInventory, state, vend_ok, vend_fail,
             fail_code, change, fault
   );
endinterface

// File: rtl/vend_sequencer.sv
// Vending sequencer: validates a selection, handshakes a dispense with timeout, and keeps
// an 8-slot 3-bit inventory with saturating restock. All outputs are registered.
module vend_sequencer #(
   parameter logic [7:0]  PRICE        = 8'd5,
   parameter int unsigned DONE_TIMEOUT = 16
) (
   input logic              clk,
   input logic              rst,
   vend_sequencer_if.slave  bus
);

   localparam int unsigned TmoW = $clog2(DONE_TIMEOUT + 1);

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StCheck    = 2'd1,
      StDispense = 2'd2,
      StRelease  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [7:0]        credit_q, credit_d;
   logic [23:0]       inv_q, inv_d;
   logic              rinv_q, rinv_d;
   logic              ok_q, ok_d;
   logic              fail_q, fail_d;
   logic [1:0]        code_q, code_d;
   logic [7:0]        change_q, change_d;
   logic              fault_q, fault_d;
   logic              ready_q, ready_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;

   logic              accept, done, timeout, dec;
   logic [2:0]        slot_cnt;
   logic              chk_fail;
   logic [1:0]        chk_code;
   logic [3:0]        slot_sum;

   assign accept  = bus.sel_valid && ready_q;
   assign done    = bus.reduceInventoryDone;
   assign timeout = !done && (tmo_q == TmoW'(DONE_TIMEOUT - 1));

   always_comb begin
      slot_cnt = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (idx_q[2:0] == 3'(i)) slot_cnt = inv_q[3*i +: 3];
      end
   end

   // Priority: bad slot, then empty slot, then insufficient credit.
   always_comb begin
      chk_fail = 1'b1;
      chk_code = 2'd0;
      if (idx_q[3])                chk_code = 2'd3;
      else if (slot_cnt == 3'd0)   chk_code = 2'd1;
      else if (credit_q < PRICE)   chk_code = 2'd2;
      else                         chk_fail = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (accept) state_d = StCheck;
         StCheck:    state_d = chk_fail ? StIdle : StDispense;
         StDispense: if (done) state_d = StRelease;
                     else if (timeout) state_d = StIdle;
         StRelease:  if (!done) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_comb begin
      idx_d    = idx_q;
      credit_d = credit_q;
      rinv_d   = rinv_q;
      ok_d     = 1'b0;
      fail_d   = 1'b0;
      code_d   = code_q;
      change_d = change_q;
      fault_d  = fault_q;
      tmo_d    = tmo_q;
      dec      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               idx_d    = bus.sel_index;
               credit_d = bus.credit;
            end
         end
         StCheck: begin
            if (chk_fail) begin
               fail_d = 1'b1;
               code_d = chk_code;
            end else begin
               rinv_d = 1'b1;
               tmo_d  = '0;
            end
         end
         StDispense: begin
            if (done) begin
               rinv_d = 1'b0;
               dec    = 1'b1;
            end else if (timeout) begin
               rinv_d  = 1'b0;
               fault_d = 1'b1;
               fail_d  = 1'b1;
               code_d  = 2'd3;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StRelease: begin
            if (!done) begin
               ok_d     = 1'b1;
               change_d = credit_q - PRICE;
            end
         end
         default: ;
      endcase
      ready_d = (state_d == StIdle) && !fault_d;
   end

   // Restock saturates before the decrement so a same-edge pair never exceeds 6.
   always_comb begin
      inv_d    = inv_q;
      slot_sum = 4'd0;
      for (int i = 0; i < 8; i++) begin
         slot_sum = {1'b0, inv_q[3*i +: 3]};
         if (bus.restock_valid && !bus.restock_index[3] && bus.restock_index[2:0] == 3'(i)) begin
            slot_sum = slot_sum + {1'b0, bus.restock_count};
            if (slot_sum > 4'd7) slot_sum = 4'd7;
         end
         if (dec && idx_q[2:0] == 3'(i)) slot_sum = slot_sum - 4'd1;
         inv_d[3*i +: 3] = slot_sum[2:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q    <= 4'd0;
         credit_q <= 8'd0;
         inv_q    <= 24'o77777777;
         rinv_q   <= 1'b0;
         ok_q     <= 1'b0;
         fail_q   <= 1'b0;
         code_q   <= 2'd0;
         change_q <= 8'd0;
         fault_q  <= 1'b0;
         ready_q  <= 1'b1;
         tmo_q    <= '0;
      end else begin
         idx_q    <= idx_d;
         credit_q <= credit_d;
         inv_q    <= inv_d;
         rinv_q   <= rinv_d;
         ok_q     <= ok_d;
         fail_q   <= fail_d;
         code_q   <= code_d;
         change_q <= change_d;
         fault_q  <= fault_d;
         ready_q  <= ready_d;
         tmo_q    <= tmo_d;
      end
   end

   assign bus.sel_ready       = ready_q;
   assign bus.reduceInventory = rinv_q;
   assign bus.curIndex        = idx_q;
   assign bus.curInventory    = inv_q;
   assign bus.state           = state_q;
   assign bus.vend_ok         = ok_q;
   assign bus.vend_fail       = fail_q;
   assign bus.fail_code       = code_q;
   assign bus.change          = change_q;
   assign bus.fault           = fault_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: nominal vend, failure causes, restock corners,
// dispense timeout and asynchronous reset.
module tb_vend_sequencer;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   logic rinv_seen;

   vend_sequencer_if bus ();

   vend_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) if (bus.reduceInventory) rinv_seen <= 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called just after a negedge; returns at the next negedge with the DUT in CHECK.
   task automatic select(input logic [3:0] idx, input logic [7:0] cr);
      bus.sel_valid = 1'b1;
      bus.sel_index = idx;
      bus.credit    = cr;
      @(negedge clk);
      bus.sel_valid = 1'b0;
   endtask

   task automatic restock(input logic [3:0] idx, input logic [2:0] cnt);
      bus.restock_valid = 1'b1;
      bus.restock_index = idx;
      bus.restock_count = cnt;
      @(negedge clk);
      bus.restock_valid = 1'b0;
   endtask

   // Full successful vend; optional restock of the same slot on the decrement edge.
   task automatic full_vend(input logic [3:0] idx, input logic [7:0] cr, input int lat,
                            input logic [2:0] rs_cnt, input string tag);
      select(idx, cr);
      check({tag, "_check_state"}, 32'(bus.state), 32'd1);
      @(negedge clk);
      check({tag, "_disp_state"}, 32'(bus.state), 32'd2);
      check({tag, "_rinv_on"}, 32'(bus.reduceInventory), 32'd1);
      repeat (lat) @(negedge clk);
      bus.reduceInventoryDone = 1'b1;
      if (rs_cnt != 3'd0) begin
         bus.restock_valid = 1'b1;
         bus.restock_index = idx;
         bus.restock_count = rs_cnt;
      end
      @(negedge clk);
      bus.restock_valid = 1'b0;
      check({tag, "_rel_state"}, 32'(bus.state), 32'd3);
      check({tag, "_rinv_off"}, 32'(bus.reduceInventory), 32'd0);
      bus.reduceInventoryDone = 1'b0;
      @(negedge clk);
      check({tag, "_ok"}, 32'(bus.vend_ok), 32'd1);
      check({tag, "_no_fail"}, 32'(bus.vend_fail), 32'd0);
      check({tag, "_change"}, 32'(bus.change), 32'(cr - 8'd5));
      check({tag, "_idle"}, 32'(bus.state), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rinv_seen = 1'b0;
      bus.sel_valid = 1'b0;
      bus.sel_index = 4'd0;
      bus.credit = 8'd0;
      bus.restock_valid = 1'b0;
      bus.restock_index = 4'd0;
      bus.restock_count = 3'd0;
      bus.reduceInventoryDone = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_inv", 32'(bus.curInventory), 32'(24'o77777777));
      check("rst_rinv", 32'(bus.reduceInventory), 32'd0);
      check("rst_ok_fail", 32'({bus.vend_ok, bus.vend_fail}), 32'd0);
      check("rst_code_change", 32'({bus.fail_code, bus.change}), 32'd0);
      check("rst_fault_idx", 32'({bus.fault, bus.curIndex}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(bus.sel_ready), 32'd1);

      // Nominal vend: slot 2, credit 8, done three cycles later.
      full_vend(4'd2, 8'd8, 3, 3'd0, "nom");
      check("nom_idx", 32'(bus.curIndex), 32'd2);
      check("nom_inv", 32'(bus.curInventory), 32'(24'o77777677));
      @(negedge clk);
      check("nom_ok_pulse", 32'(bus.vend_ok), 32'd0);
      check("nom_change_hold", 32'(bus.change), 32'd3);

      // Drain slot 0, then an empty selection must not dispense.
      for (int i = 0; i < 7; i++) full_vend(4'd0, 8'd8, 0, 3'd0, "drain");
      check("drain_inv", 32'(bus.curInventory), 32'(24'o77777670));
      rinv_seen = 1'b0;
      select(4'd0, 8'd8);
      @(negedge clk);
      check("empty_fail", 32'(bus.vend_fail), 32'd1);
      check("empty_code", 32'(bus.fail_code), 32'd1);
      check("empty_no_ok", 32'(bus.vend_ok), 32'd0);
      @(negedge clk);
      check("empty_no_rinv", 32'(rinv_seen), 32'd0);
      check("empty_code_hold", 32'(bus.fail_code), 32'd1);

      // Failure priority.
      select(4'd9, 8'd0);
      @(negedge clk);
      check("bad_idx_code", 32'({bus.vend_fail, bus.fail_code}), 32'({1'b1, 2'd3}));
      select(4'd1, 8'd4);
      @(negedge clk);
      check("low_credit_code", 32'({bus.vend_fail, bus.fail_code}), 32'({1'b1, 2'd2}));
      check("low_credit_change", 32'(bus.change), 32'd3);

      // Restock during CHECK: the check still sees the empty slot.
      bus.sel_valid = 1'b1;
      bus.sel_index = 4'd0;
      bus.credit = 8'd8;
      @(negedge clk);
      bus.sel_valid = 1'b0;
      restock(4'd0, 3'd2);
      check("chk_rs_fail", 32'({bus.vend_fail, bus.fail_code}), 32'({1'b1, 2'd1}));
      check("chk_rs_inv", 32'(bus.curInventory), 32'(24'o77777672));

      restock(4'd9, 3'd3);
      check("rs_ignore", 32'(bus.curInventory), 32'(24'o77777672));

      // Restock saturation and same-edge restock plus decrement.
      full_vend(4'd3, 8'd8, 1, 3'd0, "s3a");
      check("s3_six", 32'(bus.curInventory), 32'(24'o77776672));
      restock(4'd3, 3'd5);
      check("s3_sat", 32'(bus.curInventory), 32'(24'o77777672));
      full_vend(4'd3, 8'd10, 1, 3'd2, "s3b");
      check("s3_rs_dec", 32'(bus.curInventory), 32'(24'o77776672));

      // Timeout: done never arrives.
      select(4'd4, 8'd8);
      @(negedge clk);
      check("tmo_disp", 32'(bus.state), 32'd2);
      repeat (15) @(negedge clk);
      check("tmo_pending", 32'({bus.reduceInventory, bus.vend_fail}), 32'b10);
      @(negedge clk);
      check("tmo_fail", 32'({bus.vend_fail, bus.fail_code}), 32'({1'b1, 2'd3}));
      check("tmo_fault", 32'({bus.fault, bus.sel_ready, bus.reduceInventory}), 32'b100);
      check("tmo_inv", 32'(bus.curInventory), 32'(24'o77776672));
      check("tmo_idle", 32'(bus.state), 32'd0);
      select(4'd5, 8'd8);
      check("tmo_blocked", 32'(bus.state), 32'd0);
      @(negedge clk);
      check("tmo_sticky", 32'(bus.fault), 32'd1);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("clr_fault", 32'({bus.fault, bus.sel_ready}), 32'b01);

      // Asynchronous reset mid-dispense, then immediate reselection.
      select(4'd5, 8'd8);
      @(negedge clk);
      check("ar_rinv", 32'(bus.reduceInventory), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("ar_rinv_drop", 32'(bus.reduceInventory), 32'd0);
      check("ar_inv", 32'(bus.curInventory), 32'(24'o77777777));
      check("ar_state", 32'(bus.state), 32'd0);
      #1 rst = 1'b0;
      bus.sel_valid = 1'b1;
      bus.sel_index = 4'd6;
      bus.credit = 8'd5;
      @(negedge clk);
      bus.sel_valid = 1'b0;
      check("ar_accept", 32'({bus.state, bus.curIndex}), 32'({2'd1, 4'd6}));
      @(negedge clk);
      check("exact_credit_disp", 32'(bus.state), 32'd2);
      bus.reduceInventoryDone = 1'b1;
      @(negedge clk);
      bus.reduceInventoryDone = 1'b0;
      check("exact_credit_inv", 32'(bus.curInventory), 32'(24'o76777777));
      @(negedge clk);
      check("exact_credit_ok", 32'({bus.vend_ok, bus.change}), 32'({1'b1, 8'd0}));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter PRICE, default 8'd5, SHALL set the credit required per vend.
REQ-002 Parameter DONE_TIMEOUT, default 16, SHALL set the maximum cycles to wait for reduceInventoryDone.
REQ-003 Port list; every output SHALL be registered:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- sel_valid  in  1  selection request
- sel_index  in  4  requested slot
- sel_ready  out  1  selection accepted this cycle when high with sel_valid
- credit  in  8  credit available, sampled on accept
- restock_valid  in  1  restock strobe
- restock_index  in  4  slot to restock
- restock_count  in  3  units to add
- reduceInventory  out  1  dispense request to the dispense datapath
- reduceInventoryDone  in  1  dispense acknowledge
- curIndex  out  4  latched slot
- curInventory  out  24  8 slots x 3 bits; slot n at bits [3n+2:3n]
- state  out  2  FSM state
- vend_ok  out  1  one-cycle success pulse
- vend_fail  out  1  one-cycle failure pulse
- fail_code  out  2  failure cause, valid with vend_fail
- change  out  8  credit minus PRICE, valid with vend_ok
- fault  out  1  sticky timeout flag

Function
REQ-004 FSM encoding SHALL be IDLE=0, CHECK=1, DISPENSE=2, RELEASE=3.
REQ-005 sel_ready SHALL be 1 only in IDLE with fault=0.
REQ-006 IDLE: when sel_valid and sel_ready are both high, the block SHALL latch sel_index into curIndex and credit internally, then go to CHECK.
REQ-007 CHECK lasts one cycle. The first matching condition below, in priority order, SHALL pulse vend_fail and return to IDLE:
- curIndex>7 -> fail_code=3
- slot count=0 -> fail_code=1
- latched credit<PRICE -> fail_code=2
REQ-008 CHECK with all conditions passing SHALL go to DISPENSE and set reduceInventory=1 on the same edge.
REQ-009 DISPENSE: reduceInventory SHALL hold at 1 until reduceInventoryDone is sampled high.
REQ-010 On the edge where reduceInventoryDone is sampled high, the block SHALL decrement the slot by 1, clear reduceInventory and go to RELEASE.
REQ-011 RELEASE: when reduceInventoryDone is sampled low, the block SHALL pulse vend_ok, load change=credit-PRICE (8-bit, no wrap possible) and go to IDLE.
REQ-012 DISPENSE timeout: a cycle counter SHALL reset to 0 on entry to DISPENSE.
REQ-013 If the counter reaches DONE_TIMEOUT-1 with reduceInventoryDone still low, the block SHALL:
- clear reduceInventory
- set fault=1
- pulse vend_fail with fail_code=3
- go to IDLE with no decrement
REQ-014 fault SHALL clear only on rst; while fault=1, no selection is accepted.
REQ-015 Restock SHALL be accepted in any state.
REQ-016 Restock with restock_index<=7 SHALL add restock_count to the slot, saturating at 7.
REQ-017 Restock with restock_index>7 SHALL be ignored.
REQ-018 Restock and decrement to the same slot on the same edge SHALL yield min(count+restock_count,7)-1, computed on 4-bit intermediates.
REQ-019 A restock in CHECK SHALL take effect on the following edge; CHECK SHALL use the pre-restock count.
REQ-020 vend_ok and vend_fail SHALL never be high in the same cycle.
REQ-021 fail_code SHALL hold its last value between pulses.
REQ-022 change SHALL hold its last value between pulses.

Reset
REQ-023 Asserting rst SHALL immediately force, independent of clk:
- state=IDLE
- curInventory=24'o77777777 (all slots 7)
- reduceInventory=0, vend_ok=0, vend_fail=0
- fail_code=0, change=0, fault=0
- curIndex=0, timeout counter=0
REQ-024 Reset asserted mid-DISPENSE SHALL drop reduceInventory at once and apply no decrement.
REQ-025 After rst deasserts, the first selection SHALL be accepted on the first clk edge with sel_valid high.

Verification
REQ-026 Nominal vend: credit=8, select slot 2, done raised 3 cycles after reduceInventory, then lowered -> vend_ok pulse, change=3, slot 2 = 6.
REQ-027 Empty slot: drain slot 0 with 7 vends, then select slot 0 -> vend_fail with fail_code=1 and reduceInventory never asserted.
REQ-028 Failure priority: sel_index=9 with credit=0 -> fail_code=3; slot 1 with credit=4 -> fail_code=2.
REQ-029 Timeout: done held low -> after DONE_TIMEOUT cycles vend_fail, fail_code=3, fault=1, sel_ready=0, inventory unchanged.
REQ-030 Restock: restock slot 3 by 5 at count 6 -> 7; restock slot 3 by 2 on the same edge as its decrement at count 7 -> 6.
REQ-031 Async reset: assert rst between clk edges mid-DISPENSE -> reduceInventory=0 and all slots 7 before the next edge.
